// File: rtl/alu_sched_pkg.sv
// Shared types for the alu scheduler: op encoding and
// the buffered op bundle.
package alu_sched_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [1:0] {
      CTL_PASS = 2'd0,
      CTL_ADD  = 2'd1,
      CTL_SUB  = 2'd2,
      CTL_XOR  = 2'd3
   } alu_ctl_e;

   typedef struct packed {
      alu_ctl_e         ctl;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic             ci;
   } alu_op_t;

endpackage

// File: rtl/alu_sched_if.sv
// Requester, response and alu-side signals of the scheduler.
// slave is the scheduler view, master the environment view.
interface alu_sched_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
);
   import alu_sched_pkg::*;

   logic [NREQ-1:0]       req_push;
   logic [NREQ-1:0]       req_stop;
   logic [2*NREQ-1:0]     req_ctl;
   logic [ALU_W*NREQ-1:0] req_a;
   logic [ALU_W*NREQ-1:0] req_b;
   logic [NREQ-1:0]       req_ci;

   logic [NREQ-1:0]       rsp_push;
   logic [NREQ-1:0]       rsp_stop;
   logic [ALU_W-1:0]      rsp_z;
   logic                  rsp_cout;

   logic                  alu_pushin;
   logic                  alu_stopout;
   logic [1:0]            alu_ctl;
   logic [ALU_W-1:0]      alu_a;
   logic [ALU_W-1:0]      alu_b;
   logic                  alu_ci;
   logic                  alu_pushout;
   logic [ALU_W-1:0]      alu_z;
   logic                  alu_cout;
   logic                  alu_stopin;

   logic [CNT_W*NREQ-1:0] cnt;

   modport slave (
      input  req_push, req_ctl, req_a, req_b, req_ci,
      input  rsp_stop,
      input  alu_stopout, alu_pushout, alu_z, alu_cout,
      output req_stop, rsp_push, rsp_z, rsp_cout,
      output alu_pushin, alu_ctl, alu_a, alu_b, alu_ci,
      output alu_stopin, cnt
   );

   modport master (
      output req_push, req_ctl, req_a, req_b, req_ci,
      output rsp_stop,
      output alu_stopout, alu_pushout, alu_z, alu_cout,
      input  req_stop, rsp_push, rsp_z, rsp_cout,
      input  alu_pushin, alu_ctl, alu_a, alu_b, alu_ci,
      input  alu_stopin, cnt
   );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin picker: first requester at or above ptr,
// wrapping, when enabled.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic          i_en,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_vld
);

   logic [IW-1:0] w_j;
   logic          w_hit;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_hit   = 1'b0;
      w_j     = '0;
      if (i_en) begin
         for (int k = 0; k < N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!w_hit && i_req[w_j]) begin
               w_hit      = 1'b1;
               o_grant[w_j] = 1'b1;
               o_idx      = w_j;
            end
         end
      end
      o_vld = w_hit;
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one pipelined alu between NREQ requesters with
// 1-entry buffers, round-robin issue and tagged returns.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   alu_sched_if.slave bus
);

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]  r_vld;
   alu_op_t          r_buf [NREQ];
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_tag;
   logic [CNT_W-1:0] r_cnt [NREQ];

   logic [NREQ-1:0]  w_grant;
   logic [NREQ-1:0]  w_rsp;
   logic [IW-1:0]    w_gidx;
   logic [IW-1:0]    w_nxt;
   logic             w_gvld;
   logic             w_en;
   alu_op_t          w_op;

   assign w_en = ~bus.alu_stopout;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .i_req   (r_vld),
      .i_en    (w_en),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_vld   (w_gvld)
   );

   always_comb begin
      w_op = '0;
      if (w_gvld) w_op = r_buf[w_gidx];
   end

   assign w_nxt = (w_gidx == IW'(NREQ-1)) ? '0
                : w_gidx + 1'b1;

   assign bus.req_stop   = r_vld;
   assign bus.alu_pushin = w_gvld;
   assign bus.alu_ctl    = w_op.ctl;
   assign bus.alu_a      = w_op.a;
   assign bus.alu_b      = w_op.b;
   assign bus.alu_ci     = w_op.ci;

   assign bus.rsp_z      = bus.alu_z;
   assign bus.rsp_cout   = bus.alu_cout;
   assign bus.rsp_push   = w_rsp;
   // A stalled owner backs up the alu, which in turn blocks all issue.
   assign bus.alu_stopin = bus.alu_pushout
                         & bus.rsp_stop[r_tag];

   for (genvar g = 0; g < NREQ; g++) begin : g_req
      assign w_rsp[g] = bus.alu_pushout
                      & (r_tag == IW'(g));
      assign bus.cnt[CNT_W*g +: CNT_W] = r_cnt[g];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
         for (int i = 0; i < NREQ; i++) r_buf[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
               r_vld[i] <= 1'b0;
            end else if (bus.req_push[i] && !r_vld[i]) begin
               r_vld[i]     <= 1'b1;
               r_buf[i].ctl <= alu_ctl_e'(bus.req_ctl[2*i +: 2]);
               r_buf[i].a   <= bus.req_a[ALU_W*i +: ALU_W];
               r_buf[i].b   <= bus.req_b[ALU_W*i +: ALU_W];
               r_buf[i].ci  <= bus.req_ci[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
         r_tag <= '0;
      end else begin
         if (w_gvld) r_ptr <= w_nxt;
         if (w_en)   r_tag <= w_gidx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_rsp[i] && !bus.rsp_stop[i])
               r_cnt[i] <= r_cnt[i] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a 1-stage alu model
// on the alu side of the interface.
module tb_alu_sched;
   import alu_sched_pkg::*;

   localparam int NREQ  = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_asrt = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   alu_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic       alu_v;
   logic [7:0] alu_zr;
   logic       alu_cr;

   function automatic logic [8:0] alu_f(
      input logic [1:0] c, input logic [7:0] a,
      input logic [7:0] b, input logic ci);
      case (c)
         2'd0:    return {1'b0, a};
         2'd1:    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
         2'd2:    return {1'b0, a} - {1'b0, b} - {8'd0, ci};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   assign bus.alu_stopout = alu_v & bus.alu_stopin;
   assign bus.alu_pushout = alu_v;
   assign bus.alu_z       = alu_zr;
   assign bus.alu_cout    = alu_cr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_v  <= 1'b0;
         alu_zr <= '0;
         alu_cr <= 1'b0;
      end else if (!bus.alu_stopout) begin
         alu_v <= bus.alu_pushin;
         if (bus.alu_pushin)
            {alu_cr, alu_zr} <= alu_f(bus.alu_ctl,
               bus.alu_a, bus.alu_b, bus.alu_ci);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [1:0] c,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic ci);
      bus.req_push[i]       = 1'b1;
      bus.req_ctl[2*i +: 2] = c;
      bus.req_a[8*i +: 8]   = a;
      bus.req_b[8*i +: 8]   = b;
      bus.req_ci[i]         = ci;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b0;
      bus.req_push = '0;
      bus.req_ctl  = '0;
      bus.req_a    = '0;
      bus.req_b    = '0;
      bus.req_ci   = '0;
      bus.rsp_stop = '0;
      tick();
      tick();
      chk("rst_req_stop", bus.req_stop, 0);
      chk("rst_rsp_push", bus.rsp_push, 0);
      chk("rst_pushin", bus.alu_pushin, 0);
      chk("rst_stopin", bus.alu_stopin, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_cnt", bus.cnt, 0);
      rst = 1'b1;
      tick();

      // 1: single add, latency and count
      set_req(0, 2'd1, 8'hF0, 8'h20, 1'b1);
      tick();
      bus.req_push = '0;
      chk("t1_req_stop", bus.req_stop, 4'b0001);
      chk("t1_pushin", bus.alu_pushin, 1);
      chk("t1_alu_a", bus.alu_a, 8'hF0);
      chk("t1_alu_b", bus.alu_b, 8'h20);
      chk("t1_alu_ctl", bus.alu_ctl, 2'd1);
      chk("t1_alu_ci", bus.alu_ci, 1);
      tick();
      chk("t1_rsp_push", bus.rsp_push, 4'b0001);
      chk("t1_z", bus.rsp_z, 8'h11);
      chk("t1_cout", bus.rsp_cout, 1);
      chk("t1_req_free", bus.req_stop, 0);
      tick();
      chk("t1_rsp_done", bus.rsp_push, 0);
      chk("t1_cnt", bus.cnt, 32'h0000_0001);

      // 2: all requesters, ptr starts at 1
      for (int i = 0; i < 4; i++)
         set_req(i, 2'd0, 8'(8'h10 + i), 8'h00, 1'b0);
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 9) bus.req_push = '0;
         chk("t2_pushin", bus.alu_pushin, 1);
         chk("t2_issue", bus.alu_a, 32'(8'h10 + (1 + k) % 4));
         if (k >= 1) begin
            chk("t2_rsp", bus.rsp_push, 32'(1 << (k % 4)));
            chk("t2_z", bus.rsp_z, 32'(8'h10 + k % 4));
         end
      end
      tick();
      chk("t2_last_rsp", bus.rsp_push, 4'b0001);
      chk("t2_last_z", bus.rsp_z, 8'h10);
      chk("t2_idle", bus.alu_pushin, 0);
      tick();
      chk("t2_cnt", bus.cnt, 32'h0303_0304);

      // 3: stalled owner blocks issue
      bus.rsp_stop = 4'b0100;
      set_req(2, 2'd2, 8'd5, 8'd7, 1'b0);
      tick();
      bus.req_push = '0;
      set_req(0, 2'd0, 8'h77, 8'h00, 1'b0);
      set_req(1, 2'd0, 8'h88, 8'h00, 1'b0);
      chk("t3_pushin", bus.alu_pushin, 1);
      chk("t3_alu_a", bus.alu_a, 8'd5);
      chk("t3_alu_ctl", bus.alu_ctl, 2'd2);
      tick();
      bus.req_push = '0;
      for (int s = 0; s < 3; s++) begin
         chk("t3_rsp", bus.rsp_push, 4'b0100);
         chk("t3_z", bus.rsp_z, 8'hFE);
         chk("t3_cout", bus.rsp_cout, 1);
         chk("t3_stopin", bus.alu_stopin, 1);
         chk("t3_no_grant", bus.alu_pushin, 0);
         chk("t3_bufs", bus.req_stop, 4'b0011);
         tick();
      end
      chk("t3_cnt_hold", bus.cnt, 32'h0303_0304);
      bus.rsp_stop = '0;
      #1;
      chk("t3_rel_push", bus.alu_pushin, 1);
      chk("t3_rel_a", bus.alu_a, 8'h77);
      tick();
      chk("t3_rsp0", bus.rsp_push, 4'b0001);
      chk("t3_z0", bus.rsp_z, 8'h77);
      chk("t3_next_a", bus.alu_a, 8'h88);
      tick();
      chk("t3_rsp1", bus.rsp_push, 4'b0010);
      chk("t3_z1", bus.rsp_z, 8'h88);
      chk("t3_idle", bus.alu_pushin, 0);
      tick();
      chk("t3_cnt", bus.cnt, 32'h0304_0405);

      // 4: xor and pass routed to their owners
      set_req(1, 2'd3, 8'hAA, 8'h55, 1'b0);
      set_req(3, 2'd0, 8'h3C, 8'h00, 1'b0);
      tick();
      bus.req_push = '0;
      chk("t4_first", bus.alu_a, 8'h3C);
      tick();
      chk("t4_rsp3", bus.rsp_push, 4'b1000);
      chk("t4_z3", bus.rsp_z, 8'h3C);
      chk("t4_c3", bus.rsp_cout, 0);
      chk("t4_second", bus.alu_a, 8'hAA);
      tick();
      chk("t4_rsp1", bus.rsp_push, 4'b0010);
      chk("t4_z1", bus.rsp_z, 8'hFF);
      chk("t4_c1", bus.rsp_cout, 0);
      tick();
      chk("t4_rsp_done", bus.rsp_push, 0);
      chk("t4_cnt", bus.cnt, 32'h0404_0505);

      // 5: cnt[0] wraps
      set_req(0, 2'd1, 8'h01, 8'h01, 1'b0);
      repeat (501) tick();
      chk("t5_cnt0_max", bus.cnt[7:0], 8'hFF);
      chk("t5_cnt_rest", bus.cnt[31:8], 24'h04_0405);
      repeat (2) tick();
      chk("t5_cnt0_wrap", bus.cnt[7:0], 8'h00);
      bus.req_push = '0;
      repeat (4) tick();

      // 6: reset with full buffers and busy alu
      bus.rsp_stop = 4'b1111;
      for (int i = 0; i < 4; i++)
         set_req(i, 2'd1, 8'(i), 8'h01, 1'b0);
      repeat (3) tick();
      chk("t6_full", bus.req_stop, 4'b1111);
      chk("t6_busy", bus.alu_stopin, 1);
      chk("t6_blocked", bus.alu_pushin, 0);
      rst          = 1'b0;
      bus.req_push = '0;
      tick();
      chk("t6_req_stop", bus.req_stop, 0);
      chk("t6_rsp_push", bus.rsp_push, 0);
      chk("t6_stopin", bus.alu_stopin, 0);
      chk("t6_pushin", bus.alu_pushin, 0);
      chk("t6_cnt", bus.cnt, 0);
      bus.rsp_stop = '0;
      rst          = 1'b1;
      for (int s = 0; s < 4; s++) begin
         tick();
         chk("t6_no_stale", bus.rsp_push, 0);
         chk("t6_no_issue", bus.alu_pushin, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
